// File: rtl/smb_pkg.sv
// Shared types and constants for the write-combining store buffer.
// Entry widths follow the default configuration; the top derives its defaults from here.
package smb_pkg;

  localparam int SMB_BYTE_NUM   = 8;
  localparam int SMB_ADDR_WIDTH = 32;
  localparam int SMB_DEPTH      = 4;
  localparam int OFS_W          = $clog2(SMB_BYTE_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SMB_ADDR_WIDTH-1:0] addr;
    logic [8*SMB_BYTE_NUM-1:0] data;
    logic [SMB_BYTE_NUM-1:0]   bsel;
  } entry_t;

endpackage

// File: rtl/byte_sel.sv
// Byte-enable generator: expands a one-hot store size at a byte offset into lane enables.
// Enables that would fall past the last lane are dropped; mask forces all enables low.
module byte_sel #(
  parameter int BYTE_NUM = 8
) (
  input  logic [$clog2(BYTE_NUM)-1:0] addr,
  input  logic [BYTE_NUM/2-1:0]       size,
  input  logic                        mask,
  output logic [BYTE_NUM-1:0]         bsel
);

  int ofs_i;
  int nbytes;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    ofs_i  = int'(addr);
    nbytes = 0;
    bsel   = '0;
    for (int i = 0; i < BYTE_NUM/2; i++) begin
      if (size[i]) nbytes = 1 << i;
    end
    for (int b = 0; b < BYTE_NUM; b++) begin
      bsel[b] = !mask && (b >= ofs_i) && (b < ofs_i + nbytes);
    end
  end

endmodule

// File: rtl/store_merge_buf.sv
// Write-combining store buffer in front of the data-cache write port, drained in order.
// Define STORE_MERGE_EN to merge stores into the youngest non-head entry of the same doubleword.
module store_merge_buf
  import smb_pkg::*;
#(
  parameter int BYTE_NUM   = SMB_BYTE_NUM,
  parameter int ADDR_WIDTH = SMB_ADDR_WIDTH,
  parameter int DEPTH      = SMB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [ADDR_WIDTH-1:0]     st_addr,
  input  logic [BYTE_NUM/2-1:0]     st_size,
  input  logic [8*BYTE_NUM-1:0]     st_data,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [8*BYTE_NUM-1:0]     wr_data,
  output logic [BYTE_NUM-1:0]       wr_bsel,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t             state_q, state_d;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head, tail, tail_prev;
  logic [CNT_W-1:0]   count_q;

  logic [BYTE_NUM-1:0]   new_bsel;
  logic [8*BYTE_NUM-1:0] lane_data;
  logic [ADDR_WIDTH-1:0] st_dw;
  logic                  push_fire, pop_fire, merge, push_new;

  byte_sel #(.BYTE_NUM(BYTE_NUM)) u_byte_sel (
    .addr (st_addr[OFS_W-1:0]),
    .size (st_size),
    .mask (1'b0),
    .bsel (new_bsel)
  );

  assign lane_data = st_data << {st_addr[OFS_W-1:0], 3'b000};
  assign st_dw     = {st_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
  assign tail_prev = tail - PTR_W'(1);

  assign st_ready  = (count_q != CNT_W'(DEPTH)) && (state_q == IDLE);
  assign wr_valid  = (count_q != '0);
  assign push_fire = st_valid && st_ready;
  assign pop_fire  = wr_valid && wr_ready;

`ifdef STORE_MERGE_EN
  // count >= 2 keeps the head out of reach, so wr_* never change under a pending write.
  assign merge = (count_q >= CNT_W'(2)) && (mem[tail_prev].addr == st_dw) && (state_q == IDLE);
`else
  assign merge = 1'b0;
`endif

  assign push_new = push_fire && !merge;

  assign wr_addr = mem[head].addr;
  assign wr_data = mem[head].data;
  assign wr_bsel = mem[head].bsel;
  assign count   = count_q;

  // NOTE: entries are reset (not left uninitialised) because wr_* must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_fire) begin
      if (merge) begin
        for (int b = 0; b < BYTE_NUM; b++) begin
          if (new_bsel[b]) mem[tail_prev].data[8*b +: 8] <= lane_data[8*b +: 8];
        end
        mem[tail_prev].bsel <= mem[tail_prev].bsel | new_bsel;
      end else begin
        mem[tail] <= '{addr: st_dw, data: lane_data, bsel: new_bsel};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push_new) tail <= tail + PTR_W'(1);
      if (pop_fire) head <= head + PTR_W'(1);
      unique case ({push_new, pop_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      IDLE:    if (flush_req) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_merge_buf.sv
// Directed bench for store_merge_buf: single-store vector table plus merge, full, wrap,
// flush and reset sequences. Inputs change and outputs are sampled on the falling edge.
module tb_store_merge_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_size;
  logic [63:0] st_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_bsel;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  store_merge_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_size    (st_size),
    .st_data    (st_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_bsel    (wr_bsel),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .count      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  size;
    logic [63:0] data;
    logic [31:0] exp_addr;
    logic [7:0]  exp_bsel;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one store for one cycle; called and returns on a falling edge.
  task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [63:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_size  = s;
    st_data  = d;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  initial begin
    int pops, dones, sent, got, mcount, push, pop;
    logic [31:0] q [$];

    vecs[0] = '{32'h1003, 4'b0001, 64'hAB,               32'h1000, 8'h08, 64'h0000_0000_AB00_0000};
    vecs[1] = '{32'h2006, 4'b0010, 64'hBEEF,             32'h2000, 8'hC0, 64'hBEEF_0000_0000_0000};
    vecs[2] = '{32'h300C, 4'b0100, 64'hDEAD_BEEF,        32'h3008, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[3] = '{32'h4008, 4'b1000, 64'h0123456789ABCDEF, 32'h4008, 8'hFF, 64'h0123456789ABCDEF};
    vecs[4] = '{32'h5007, 4'b0001, 64'h77,               32'h5000, 8'h80, 64'h7700_0000_0000_0000};
    vecs[5] = '{32'h6002, 4'b0010, 64'h1234,             32'h6000, 8'h0C, 64'h0000_0000_1234_0000};

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    wr_ready = 1'b0; flush_req = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_st_ready",   st_ready,   1);
    check("rst_wr_valid",   wr_valid,   0);
    check("rst_wr_addr",    wr_addr,    0);
    check("rst_wr_data",    wr_data,    0);
    check("rst_wr_bsel",    wr_bsel,    0);
    check("rst_flush_done", flush_done, 0);
    check("rst_count",      count,      0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single stores through an empty buffer with the cache always ready.
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      store(vecs[i].addr, vecs[i].size, vecs[i].data);
      check($sformatf("vec%0d_wr_valid", i), wr_valid, 1);
      check($sformatf("vec%0d_count1", i),   count,    1);
      check($sformatf("vec%0d_wr_addr", i),  wr_addr,  vecs[i].exp_addr);
      check($sformatf("vec%0d_wr_bsel", i),  wr_bsel,  vecs[i].exp_bsel);
      check($sformatf("vec%0d_wr_data", i),  wr_data,  vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_count0", i),   count,    0);
    end

    // Merge into the youngest non-head entry.
    wr_ready = 1'b0;
    store(32'h2000, 4'b1000, 64'hCAFE_F00D_0BAD_BEEF);
    store(32'h3000, 4'b0010, 64'h1111);
    store(32'h3002, 4'b0010, 64'h2222);
`ifdef STORE_MERGE_EN
    check("merge_count", count, 2);
`else
    check("merge_count", count, 3);
`endif
    check("merge_head_addr", wr_addr, 32'h2000);
    wr_ready = 1'b1;
    @(negedge clk);
    check("merge_e1_addr", wr_addr, 32'h3000);
`ifdef STORE_MERGE_EN
    check("merge_e1_bsel", wr_bsel, 8'h0F);
    check("merge_e1_data", wr_data[31:0], 32'h2222_1111);
`else
    check("merge_e1_bsel", wr_bsel, 8'h03);
    check("merge_e1_data", wr_data[31:0], 32'h0000_1111);
    @(negedge clk);
    check("merge_e2_addr", wr_addr, 32'h3000);
    check("merge_e2_bsel", wr_bsel, 8'h0C);
    check("merge_e2_data", wr_data[31:0], 32'h2222_0000);
`endif
    @(negedge clk);
    check("merge_drained", count, 0);

    // The head entry is never a merge target.
    wr_ready = 1'b0;
    store(32'h7000, 4'b0001, 64'h11);
    store(32'h7001, 4'b0001, 64'h22);
    check("nohead_count", count, 2);
    check("nohead_bsel",  wr_bsel, 8'h01);
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("nohead_drained", count, 0);

    // Full and backpressure.
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h100 * (i + 1), 4'b1000, 64'(i));
    check("full_count",    count,    4);
    check("full_st_ready", st_ready, 0);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_order%0d", i), wr_addr, 32'h100 * (i + 1));
      @(negedge clk);
      check($sformatf("full_st_ready%0d", i), st_ready, 1);
    end
    check("full_drained", count, 0);

    // Pointer wrap with a toggling cache ready; scoreboard holds expected order.
    sent = 0; got = 0; mcount = 0;
    for (int c = 0; c < 100 && got < 10; c++) begin
      wr_ready = (c % 2 == 0);
      st_valid = 1'b0;
      push = 0; pop = 0;
      if (sent < 10 && st_ready) begin
        st_valid = 1'b1;
        st_addr  = 32'h8000 + 32'(sent) * 8;
        st_size  = 4'b1000;
        st_data  = 64'(sent);
        q.push_back(st_addr);
        sent++;
        push = 1;
      end
      if (wr_valid && wr_ready) begin
        check("wrap_order", wr_addr, q[0]);
        void'(q.pop_front());
        got++;
        pop = 1;
      end
      @(negedge clk);
      mcount += push - pop;
      check("wrap_count", count, mcount);
      n_cmp++;
      if (count > 3'd4) begin
        n_fail++;
        $display("FAIL wrap_count_max: got %0d expected at most 4", count);
      end
    end
    st_valid = 1'b0;
    check("wrap_sent", sent, 10);
    check("wrap_got",  got,  10);

    // Flush with three entries.
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'hA000 + 32'(i) * 8, 4'b0001, 64'(i));
    flush_req = 1'b1; wr_ready = 1'b1;
    pops = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (wr_valid) pops++;
      if (flush_done) begin
        dones++;
        check("flush_done_cycle", c, 4);
        flush_req = 1'b0;
      end
      if (c >= 1 && c <= 4) check("flush_st_ready", st_ready, 0);
      @(negedge clk);
    end
    check("flush_pops",  pops,  3);
    check("flush_dones", dones, 1);
    check("flush_after_ready", st_ready, 1);

    // Flush on an empty buffer.
    flush_req = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (flush_done) begin
        dones++;
        check("empty_flush_cycle", c, 2);
        flush_req = 1'b0;
      end
      @(negedge clk);
    end
    check("empty_flush_dones", dones, 1);

    // Asynchronous reset while stuck in a drain.
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'hB000 + 32'(i) * 8, 4'b0001, 64'(i));
    flush_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_count", count, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_valid", wr_valid, 0);
    check("rst_mid_count",    count,    0);
    flush_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_st_ready", st_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
